// File: rtl/acc_avg_readout.sv
// acc_avg_readout: frame controller for the echo accumulator; emits a rounded, saturated average per frame
module acc_avg_readout #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 16,
    parameter int LOG2N = 8,
    parameter bit CONT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sample_stb_i,
    input  logic [ACC_W-1:0] acc_value_i,
    output logic             acc_clr_o,
    output logic             acc_en_o,
    output logic [OUT_W-1:0] avg_data_o,
    output logic             avg_valid_o,
    input  logic             avg_ready_i,
    output logic             busy_o,
    output logic             overrun_o
);
    localparam int CW = LOG2N + 1;
    localparam logic [CW-1:0] LAST = CW'((2 ** LOG2N) - 1);
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'((2 ** LOG2N) >> 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, CALC, OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic [OUT_W-1:0] avg_q, avg_d;
    logic [ACC_W:0]   sum, q;

    // state, sample counter, sticky overrun flag and latched average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            avg_q   <= avg_d;
        end
    end

    // frame sequencing; a completed handshake either idles or rearms the next frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? CLEAR : IDLE;
            CLEAR:   state_d = ACCUM;
            ACCUM:   state_d = (sample_stb_i && cnt_q == LAST) ? SETTLE : ACCUM;
            SETTLE:  state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     state_d = avg_ready_i ? (CONT ? CLEAR : IDLE) : OUT;
            default: state_d = IDLE;
        endcase
    end

    // counting, overrun detection and round-half-up average with saturation
    always_comb begin
        sum   = {1'b0, acc_value_i} + HALF;
        q     = sum >> LOG2N;
        cnt_d = (state_q == CLEAR) ? '0 : (state_q == ACCUM && sample_stb_i) ? cnt_q + 1'b1 : cnt_q;
        ovr_d = (state_q == IDLE && start_i) ? 1'b0 :
                (sample_stb_i && state_q inside {SETTLE, CALC, OUT}) ? 1'b1 : ovr_q;
        avg_d = (state_q == CALC) ? ((|q[ACC_W:OUT_W]) ? '1 : q[OUT_W-1:0]) : avg_q;
    end

    // outputs decoded from the current state
    always_comb begin
        acc_clr_o   = state_q == CLEAR;
        acc_en_o    = state_q == ACCUM;
        avg_valid_o = state_q == OUT;
        busy_o      = state_q != IDLE;
        avg_data_o  = avg_q;
        overrun_o   = ovr_q;
    end
endmodule

// File: tb/tb_acc_avg_readout.sv
// tb_acc_avg_readout: directed/random frames against an arithmetic average model
module tb_acc_avg_readout;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start = 0, stb = 0, rdy = 0;
    logic [11:0] samp = '0;
    logic [19:0] acc;
    logic        clr, en, valid, busy, ovr;
    logic [15:0] data;

    acc_avg_readout dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .sample_stb_i(stb), .acc_value_i(acc),
        .acc_clr_o(clr), .acc_en_o(en), .avg_data_o(data), .avg_valid_o(valid),
        .avg_ready_i(rdy), .busy_o(busy), .overrun_o(ovr)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (en && stb) acc <= acc + 20'(samp);

    logic        start0 = 0, stb0 = 0, rdy0 = 0;
    logic [19:0] acc0 = '0;
    logic        clr0, en0, valid0, busy0, ovr0;
    logic [15:0] data0;

    acc_avg_readout #(.LOG2N(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .sample_stb_i(stb0), .acc_value_i(acc0),
        .acc_clr_o(clr0), .acc_en_o(en0), .avg_data_o(data0), .avg_valid_o(valid0),
        .avg_ready_i(rdy0), .busy_o(busy0), .overrun_o(ovr0)
    );

    logic        startc = 0, stbc = 0;
    logic [11:0] sampc = '0;
    logic [19:0] accc;
    logic        clrc, enc, validc, busyc, ovrc;
    logic [15:0] datac;
    int          clr_cnt;

    acc_avg_readout #(.LOG2N(2), .CONT(1'b1)) dutc (
        .clk(clk), .rst_n(rst_n), .start_i(startc), .sample_stb_i(stbc), .acc_value_i(accc),
        .acc_clr_o(clrc), .acc_en_o(enc), .avg_data_o(datac), .avg_valid_o(validc),
        .avg_ready_i(1'b1), .busy_o(busyc), .overrun_o(ovrc)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) accc <= '0;
        else if (clrc) accc <= '0;
        else if (enc && stbc) accc <= accc + 20'(sampc);

    always @(posedge clk or negedge rst_n)
        if (!rst_n) clr_cnt <= 0;
        else if (clrc) clr_cnt <= clr_cnt + 1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    bit ovr_exp = 0;

    // mode: 0 random, 1 constant 100, 2 sum 384, 3 sum 383
    task automatic frame(input int mode, input int hold, input bit stray, input bit poke);
        int sum, v, e;
        sum   = 0;
        rdy   = (hold == 0);
        start = 1; tick; start = 0;
        ovr_exp = 0;
        chk("clr_after_start", clr, 1);
        chk("ovr_cleared", ovr, 0);
        stb = stray; tick; stb = 0;
        chk("clr_one_cycle", clr, 0);
        chk("en_accum", en, 1);
        for (int i = 0; i < 256; i++) begin
            v = mode == 0 ? int'($urandom_range(0, 4095)) : mode == 1 ? 100 :
                mode == 2 ? (i < 128 ? 2 : 1) : (i < 127 ? 2 : 1);
            if (poke && i == 10) begin
                start = 1; tick; start = 0;
                chk("start_ignored", clr, 0);
            end
            repeat ($urandom_range(0, 1)) tick;
            stb = 1; samp = 12'(v); sum += v; tick; stb = 0;
        end
        chk("en_drop", en, 0);
        chk("valid_settle", valid, 0);
        tick;
        chk("valid_calc", valid, 0);
        tick;
        e = (sum + 128) / 256;
        if (e > 65535) e = 65535;
        chk("valid_lat3", valid, 1);
        chk("avg_data", data, e);
        chk("acc_sum", acc, sum);
        if (hold > 0) begin
            stb = 1; tick; stb = 0; ovr_exp = 1;
            repeat (hold - 1) tick;
            chk("valid_held", valid, 1);
            chk("data_held", data, e);
            chk("ovr_set", ovr, 1);
        end
        rdy = 1; tick; rdy = 0;
        chk("valid_clr", valid, 0);
        chk("idle_after_accept", busy, 0);
        chk("ovr_sticky", ovr, ovr_exp);
    endtask

    initial begin
        logic [19:0] vals[4];
        int sum, e;
        vals = '{20'hFFFFF, 20'h10000, 20'h0FFFF, 20'd1234};
        tick; tick;
        chk("rst_clr", clr, 0);
        chk("rst_en", en, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_data", data, 0);
        rst_n = 1; tick;
        stb = 1; tick; stb = 0;
        chk("idle_stb_noovr", ovr, 0);
        chk("idle_stb_nobusy", busy, 0);

        frame(1, 0, 1, 1);
        frame(2, 0, 0, 0);
        frame(3, 0, 0, 0);
        frame(0, 10, 0, 0);
        frame(0, 0, 0, 0);

        start = 1; tick; start = 0; tick;
        for (int i = 0; i < 100; i++) begin
            stb = 1; samp = 12'($urandom_range(0, 4095)); tick; stb = 0;
        end
        rst_n = 0; #1;
        chk("midrst_clr", clr, 0);
        chk("midrst_en", en, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);
        tick; rst_n = 1; tick;
        stb = 1; tick; stb = 0;
        chk("post_rst_stray_busy", busy, 0);
        chk("post_rst_stray_ovr", ovr, 0);
        frame(0, 0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            start0 = 1; tick; start0 = 0;
            chk("l0_clr", clr0, 1);
            tick;
            chk("l0_en", en0, 1);
            acc0 = vals[k]; stb0 = 1; tick; stb0 = 0;
            tick; tick;
            chk("l0_valid", valid0, 1);
            chk("l0_data", data0, vals[k] > 20'hFFFF ? 32'hFFFF : 32'(vals[k]));
            rdy0 = 1; tick; rdy0 = 0;
            chk("l0_valid_clr", valid0, 0);
            chk("l0_idle", busy0, 0);
        end
        chk("l0_ovr", ovr0, 0);

        startc = 1; tick; startc = 0;
        for (int f = 0; f < 3; f++) begin
            tick;
            chk("cont_en", enc, 1);
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                if (i == 1) begin startc = 1; tick; startc = 0; end
                stbc = 1; sampc = 12'($urandom_range(0, 4095)); sum += int'(sampc); tick; stbc = 0;
            end
            tick; tick;
            e = (sum + 2) / 4;
            chk("cont_valid", validc, 1);
            chk("cont_data", datac, e);
            tick;
            chk("cont_reclr", clrc, 1);
            chk("cont_valid_clr", validc, 0);
            chk("cont_busy", busyc, 1);
        end
        tick;
        chk("cont_clr_count", clr_cnt, 4);
        chk("cont_clr_pulse", clrc, 0);
        chk("cont_ovr", ovrc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
